block_ram_dp: RTL and testbench

Parametrised true-dual-port block RAM. It succeeds the single-cycle byte-enabled dual-port RAM used for CPU instruction and data memory. It adds per-port request enables and read-valid outputs, a configurable read pipeline depth, a selectable same-port read-during-write mode, deterministic write-collision resolution and a sticky collision flag. It sits between the fetch/load-store units and on-chip memory.

---
 rtl/block_ram_dp_if.sv | 39 +++
 rtl/block_ram_dp.sv | 108 ++++++++++
 tb/tb_block_ram_dp.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/block_ram_dp_if.sv
// Request/response bundle for the true-dual-port block RAM: two independent
// request ports plus the sticky write-collision flag and its clear.
interface block_ram_dp_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  logic                  en_a;
  logic [NumBytes-1:0]   we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic                  rvalid_a;

  logic                  en_b;
  logic [NumBytes-1:0]   we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  rvalid_b;

  logic                  collision;
  logic                  collision_clr;

  modport master (
    output en_a, we_a, addr_a, wdata_a,
    output en_b, we_b, addr_b, wdata_b,
    output collision_clr,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b, collision
  );

  modport slave (
    input  en_a, we_a, addr_a, wdata_a,
    input  en_b, we_b, addr_b, wdata_b,
    input  collision_clr,
    output rdata_a, rvalid_a, rdata_b, rvalid_b, collision
  );
endinterface

// File: rtl/block_ram_dp.sv
// True-dual-port byte-enabled block RAM with 1- or 2-cycle read pipeline,
// selectable same-port read-during-write and port-A-wins write collisions.
module block_ram_dp #(
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          WRITE_FIRST  = 1'b0
) (
  input logic           clk,
  input logic           resetn,
  block_ram_dp_if.slave bus_io
);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("block_ram_dp: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("block_ram_dp: DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [DATA_WIDTH-1:0] rd_a_d, rd_b_d;
  logic [DATA_WIDTH-1:0] rdata_s1_a_q, rdata_s1_b_q;
  logic                  rvalid_s1_a_q, rvalid_s1_b_q;
  logic                  same_addr, coll_hit;
  logic                  collision_d, collision_q;

  assign same_addr = bus_io.addr_a == bus_io.addr_b;
  assign coll_hit  = bus_io.en_a && bus_io.en_b && same_addr &&
                     ((bus_io.we_a & bus_io.we_b) != '0);
  assign collision_d = coll_hit || (collision_q && !bus_io.collision_clr);

  // Reads see the pre-write array; write-first only merges the port's own bytes,
  // so a cross-port write to the same word is never visible in this cycle.
  always_comb begin
    rd_a_d = mem_q[bus_io.addr_a];
    rd_b_d = mem_q[bus_io.addr_b];
    if (WRITE_FIRST) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (bus_io.we_a[i]) rd_a_d[8*i+:8] = bus_io.wdata_a[8*i+:8];
        if (bus_io.we_b[i]) rd_b_d[8*i+:8] = bus_io.wdata_b[8*i+:8];
      end
    end
  end

  // Port B is suppressed only on bytes port A also writes at the same address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumBytes; i++) begin
      if (bus_io.en_a && bus_io.we_a[i]) begin
        mem_q[bus_io.addr_a][8*i+:8] <= bus_io.wdata_a[8*i+:8];
      end
      if (bus_io.en_b && bus_io.we_b[i] &&
          !(bus_io.en_a && bus_io.we_a[i] && same_addr)) begin
        mem_q[bus_io.addr_b][8*i+:8] <= bus_io.wdata_b[8*i+:8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_s1_a_q  <= '0;
      rdata_s1_b_q  <= '0;
      rvalid_s1_a_q <= 1'b0;
      rvalid_s1_b_q <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      rvalid_s1_a_q <= bus_io.en_a;
      rvalid_s1_b_q <= bus_io.en_b;
      if (bus_io.en_a) rdata_s1_a_q <= rd_a_d;
      if (bus_io.en_b) rdata_s1_b_q <= rd_b_d;
      collision_q   <= collision_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rdata_s2_a_q, rdata_s2_b_q;
    logic                  rvalid_s2_a_q, rvalid_s2_b_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rdata_s2_a_q  <= '0;
        rdata_s2_b_q  <= '0;
        rvalid_s2_a_q <= 1'b0;
        rvalid_s2_b_q <= 1'b0;
      end else begin
        rvalid_s2_a_q <= rvalid_s1_a_q;
        rvalid_s2_b_q <= rvalid_s1_b_q;
        if (rvalid_s1_a_q) rdata_s2_a_q <= rdata_s1_a_q;
        if (rvalid_s1_b_q) rdata_s2_b_q <= rdata_s1_b_q;
      end
    end

    assign bus_io.rdata_a  = rdata_s2_a_q;
    assign bus_io.rdata_b  = rdata_s2_b_q;
    assign bus_io.rvalid_a = rvalid_s2_a_q;
    assign bus_io.rvalid_b = rvalid_s2_b_q;
  end else begin : g_lat1
    assign bus_io.rdata_a  = rdata_s1_a_q;
    assign bus_io.rdata_b  = rdata_s1_b_q;
    assign bus_io.rvalid_a = rvalid_s1_a_q;
    assign bus_io.rvalid_b = rvalid_s1_b_q;
  end

  assign bus_io.collision = collision_q;
endmodule

// File: tb/tb_block_ram_dp.sv
// Randomised bench for block_ram_dp: two instances (latency 1/read-first and
// latency 2/write-first) share stimulus and are checked against a word-level model.
module tb_block_ram_dp;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  block_ram_dp_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus0 ();
  block_ram_dp_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus1 ();

  block_ram_dp #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(1), .WRITE_FIRST(1'b0)) u_dut0 (
    .clk    (clk),
    .resetn (resetn),
    .bus_io (bus0.slave)
  );

  block_ram_dp #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(2), .WRITE_FIRST(1'b1)) u_dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus_io (bus1.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: memory words, expected read completions per (dut, port), collision flag.
  logic [31:0] mem_m [512];
  int          due_q [4][$];
  logic [31:0] dat_q [4][$];
  logic [31:0] last_m [4];
  logic        coll_m;
  string       pname [4] = '{"d0_a", "d0_b", "d1_a", "d1_b"};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i+:8] = wd[8*i+:8];
    return r;
  endfunction

  function automatic logic [31:0] get_rdata(input int k);
    case (k)
      0:       return bus0.rdata_a;
      1:       return bus0.rdata_b;
      2:       return bus1.rdata_a;
      default: return bus1.rdata_b;
    endcase
  endfunction

  function automatic logic get_rvalid(input int k);
    case (k)
      0:       return bus0.rvalid_a;
      1:       return bus0.rvalid_b;
      2:       return bus1.rvalid_a;
      default: return bus1.rvalid_b;
    endcase
  endfunction

  task automatic set_bus(input logic ena, input logic [3:0] wea, input logic [8:0] aa,
                         input logic [31:0] wda, input logic enb, input logic [3:0] web,
                         input logic [8:0] ab, input logic [31:0] wdb, input logic clr);
    bus0.en_a = ena; bus0.we_a = wea; bus0.addr_a = aa; bus0.wdata_a = wda;
    bus0.en_b = enb; bus0.we_b = web; bus0.addr_b = ab; bus0.wdata_b = wdb;
    bus0.collision_clr = clr;
    bus1.en_a = ena; bus1.we_a = wea; bus1.addr_a = aa; bus1.wdata_a = wda;
    bus1.en_b = enb; bus1.we_b = web; bus1.addr_b = ab; bus1.wdata_b = wdb;
    bus1.collision_clr = clr;
  endtask

  task automatic check_outputs();
    logic exp_v;
    for (int k = 0; k < 4; k++) begin
      exp_v = (due_q[k].size() > 0) && (due_q[k][0] == cyc);
      check_eq({pname[k], "_rvalid"}, {31'b0, get_rvalid(k)}, {31'b0, exp_v});
      if (exp_v) begin
        last_m[k] = dat_q[k].pop_front();
        void'(due_q[k].pop_front());
      end
      check_eq({pname[k], "_rdata"}, get_rdata(k), last_m[k]);
    end
    check_eq("d0_collision", {31'b0, bus0.collision}, {31'b0, coll_m});
    check_eq("d1_collision", {31'b0, bus1.collision}, {31'b0, coll_m});
  endtask

  // Apply one cycle of requests, predict results from the model, then check after the edge.
  task automatic drive_cycle(input logic ena, input logic [3:0] wea, input logic [8:0] aa,
                             input logic [31:0] wda, input logic enb, input logic [3:0] web,
                             input logic [8:0] ab, input logic [31:0] wdb, input logic clr);
    logic [31:0] olda, oldb;
    set_bus(ena, wea, aa, wda, enb, web, ab, wdb, clr);
    olda = mem_m[aa];
    oldb = mem_m[ab];
    for (int d = 0; d < 2; d++) begin
      if (ena) begin
        due_q[2*d].push_back(cyc + lat(d));
        dat_q[2*d].push_back((d == 1) ? merge(olda, wda, wea) : olda);
      end
      if (enb) begin
        due_q[2*d+1].push_back(cyc + lat(d));
        dat_q[2*d+1].push_back((d == 1) ? merge(oldb, wdb, web) : oldb);
      end
    end
    if (ena && enb && aa == ab && (wea & web) != 4'h0) coll_m = 1'b1;
    else if (clr) coll_m = 1'b0;
    // B first so that A overwrites any shared bytes.
    if (enb) mem_m[ab] = merge(mem_m[ab], wdb, web);
    if (ena) mem_m[aa] = merge(mem_m[aa], wda, wea);
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 4'h0, 9'h0, 32'h0, 0, 4'h0, 9'h0, 32'h0, 0);
  endtask

  task automatic apply_reset();
    set_bus(0, 4'h0, 9'h0, 32'h0, 0, 4'h0, 9'h0, 32'h0, 0);
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq({pname[k], "_rst_rvalid"}, {31'b0, get_rvalid(k)}, 32'h0);
      check_eq({pname[k], "_rst_rdata"}, get_rdata(k), 32'h0);
      due_q[k].delete();
      dat_q[k].delete();
      last_m[k] = 32'h0;
    end
    check_eq("d0_rst_collision", {31'b0, bus0.collision}, 32'h0);
    check_eq("d1_rst_collision", {31'b0, bus1.collision}, 32'h0);
    coll_m = 1'b0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  initial begin
    logic [31:0] wa, wb;
    for (int i = 0; i < 512; i++) mem_m[i] = 32'h0;
    for (int k = 0; k < 4; k++) last_m[k] = 32'h0;
    coll_m = 1'b0;
    #2;
    apply_reset();

    // Zero the whole array so the model and RAM start from a known image.
    for (int i = 0; i < 256; i++)
      drive_cycle(1, 4'hF, 9'(i), 32'h0, 1, 4'hF, 9'(i + 256), 32'h0, 0);
    idle(3);

    // Write on A, read back on B.
    drive_cycle(1, 4'hF, 9'h010, 32'hDEADBEEF, 0, 4'h0, 9'h0, 32'h0, 0);
    drive_cycle(0, 4'h0, 9'h0, 32'h0, 1, 4'h0, 9'h010, 32'h0, 0);
    idle(3);

    // Byte enables.
    drive_cycle(1, 4'hF, 9'h020, 32'h11223344, 0, 4'h0, 9'h0, 32'h0, 0);
    drive_cycle(1, 4'h5, 9'h020, 32'hAABBCCDD, 0, 4'h0, 9'h0, 32'h0, 0);
    drive_cycle(1, 4'h0, 9'h020, 32'h0, 0, 4'h0, 9'h0, 32'h0, 0);
    idle(3);

    // Same-port and cross-port read-during-write.
    drive_cycle(1, 4'hF, 9'h030, 32'h12345678, 1, 4'h0, 9'h030, 32'h0, 0);
    idle(3);

    // Collision, clear, then clear together with a fresh collision.
    drive_cycle(1, 4'h3, 9'h1FF, 32'hAAAAAAAA, 1, 4'h6, 9'h1FF, 32'hBBBBBBBB, 0);
    drive_cycle(1, 4'h0, 9'h1FF, 32'h0, 0, 4'h0, 9'h0, 32'h0, 0);
    idle(2);
    drive_cycle(0, 4'h0, 9'h0, 32'h0, 0, 4'h0, 9'h0, 32'h0, 1);
    idle(1);
    drive_cycle(1, 4'h1, 9'h1FE, 32'h01010101, 1, 4'h1, 9'h1FE, 32'h02020202, 0);
    drive_cycle(1, 4'h8, 9'h1FD, 32'h03030303, 1, 4'h8, 9'h1FD, 32'h04040404, 1);
    idle(2);
    drive_cycle(0, 4'h0, 9'h0, 32'h0, 0, 4'h0, 9'h0, 32'h0, 1);
    idle(1);

    // Fill 16 words per port, then stream them back with no gaps.
    for (int i = 0; i < 16; i++) begin
      wa = $urandom;
      wb = $urandom;
      drive_cycle(1, 4'hF, 9'(i + 64), wa, 1, 4'hF, 9'(i + 320), wb, 0);
    end
    for (int i = 0; i < 16; i++)
      drive_cycle(1, 4'h0, 9'(i + 64), 32'h0, 1, 4'h0, 9'(i + 320), 32'h0, 0);
    idle(3);

    // Random traffic on a narrow window to provoke collisions and RDW hazards.
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 4'($urandom), 9'(9'h1F0 + $urandom_range(0, 7)),
                  $urandom, $urandom_range(0, 3) != 0, 4'($urandom),
                  9'(9'h1F0 + $urandom_range(0, 7)), $urandom, $urandom_range(0, 7) == 0);
    end
    idle(3);

    // Reset while reads are in flight; array contents must survive.
    drive_cycle(1, 4'h0, 9'h010, 32'h0, 1, 4'h0, 9'h020, 32'h0, 0);
    apply_reset();
    idle(4);
    drive_cycle(1, 4'h0, 9'h010, 32'h0, 1, 4'h0, 9'h020, 32'h0, 0);
    drive_cycle(1, 4'h0, 9'h1FF, 32'h0, 1, 4'h0, 9'h030, 32'h0, 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
